multicycle_core: RTL

- Parametrised multi-cycle successor to the single-cycle LEGv8-subset datapath: one FSM sequences fetch, decode, execute, memory and write-back over several clocks.
- PC, register file, ALU, immediate extraction and control live in one block.
- Instruction and data accesses share a single unified memory port with a valid/ready handshake, so wait-state memories are supported.
- Adds reset, illegal-instruction halt, retire pulse and a register debug read port.

---
 rtl/multicycle_core.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle LEGv8-subset core: one FSM sequences fetch/decode/exec/mem/wb
// over a single unified valid/ready memory port.
module multicycle_core #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, retire_q, retire_d;
    logic [DATA_W-1:0] regs_q [32];

    logic [10:0]       op11;
    logic              is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_cbz, is_b;
    logic              is_r, legal, hs, wr_en;
    logic [DATA_W-1:0] rn_val, rm_val, rt_val, alu_res, wb_data;
    logic [DATA_W-1:0] mem_off, cbz_off, b_off;
    logic [4:0]        rn, rm, rd;

    assign op11    = ir_q[31:21];
    assign rd      = ir_q[4:0];
    assign rn      = ir_q[9:5];
    assign rm      = ir_q[20:16];
    assign is_add  = (op11 == 11'b10001011000);
    assign is_sub  = (op11 == 11'b11001011000);
    assign is_and  = (op11 == 11'b10001010000);
    assign is_orr  = (op11 == 11'b10101010000);
    assign is_ldur = (op11 == 11'b11111000010);
    assign is_stur = (op11 == 11'b11111000000);
    assign is_cbz  = (ir_q[31:24] == 8'b10110100);
    assign is_b    = (ir_q[31:26] == 6'b000101);
    assign is_r    = is_add | is_sub | is_and | is_orr;
    assign legal   = is_r | is_ldur | is_stur | is_cbz | is_b;
    assign hs      = mem_req_q & mem_ready;

    assign rn_val  = (rn == 5'd31) ? '0 : regs_q[rn];
    assign rm_val  = (rm == 5'd31) ? '0 : regs_q[rm];
    assign rt_val  = (rd == 5'd31) ? '0 : regs_q[rd];

    assign mem_off = DATA_W'($signed(ir_q[20:12]));
    assign cbz_off = DATA_W'($signed(ir_q[23:5])) << 2;
    assign b_off   = DATA_W'($signed(ir_q[25:0])) << 2;

    always_comb begin
        if (is_sub)      alu_res = a_q - b_q;
        else if (is_and) alu_res = a_q & b_q;
        else if (is_orr) alu_res = a_q | b_q;
        else             alu_res = a_q + b_q;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (hs) state_d = S_DECODE;
            S_DECODE: state_d = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_r)                   state_d = S_WB;
                else if (is_ldur | is_stur) state_d = S_MEM;
                else                        state_d = S_FETCH;
            end
            S_MEM:    if (hs) state_d = is_stur ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        retire_d  = 1'b0;
        wr_en     = 1'b0;
        wb_data   = is_ldur ? mdr_q : alu_out_q;
        case (state_q)
            S_FETCH:  if (hs) ir_d = mem_rdata;
            S_DECODE: begin
                a_d = rn_val;
                b_d = is_r ? rm_val : rt_val;
            end
            S_EXEC: begin
                if (is_r) alu_out_d = alu_res;
                else if (is_ldur | is_stur) alu_out_d = a_q + mem_off;
                else if (is_cbz) begin
                    pc_d     = (b_q == '0) ? pc_q + cbz_off[ADDR_W-1:0] : pc_q + ADDR_W'(4);
                    retire_d = 1'b1;
                end else if (is_b) begin
                    pc_d     = pc_q + b_off[ADDR_W-1:0];
                    retire_d = 1'b1;
                end
            end
            S_MEM: begin
                if (hs && is_stur) begin
                    pc_d     = pc_q + ADDR_W'(4);
                    retire_d = 1'b1;
                end else if (hs) begin
                    mdr_d = mem_rdata;
                end
            end
            S_WB: begin
                wr_en    = (rd != 5'd31);
                pc_d     = pc_q + ADDR_W'(4);
                retire_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Memory outputs are registered from the next state so a request is already
    // on the port in the first cycle of FETCH/MEM, and held while waiting.
    always_comb begin
        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d    = (state_d == S_MEM) && is_stur;
        mem_addr_d  = (state_d == S_MEM) ? alu_out_d[ADDR_W-1:0] : pc_d;
        mem_wdata_d = b_q;
        halted      = (state_q == S_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            mdr_q       <= '0;
            retire_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_out_q   <= alu_out_d;
            mdr_q       <= mdr_d;
            retire_q    <= retire_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[rd] <= wb_data;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign dbg_rdata = (dbg_raddr == 5'd31) ? '0 : regs_q[dbg_raddr];

endmodule
